// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, FSM state type and default datapath width.
// Used by alu_issue_ctrl, shift_add_mul and the ALUControl decoder.
package alu_ctrl_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] CTRL_ADD = 3'b000;
    localparam logic [2:0] CTRL_SUB = 3'b001;
    localparam logic [2:0] CTRL_MUL = 3'b010;
    localparam logic [2:0] CTRL_OR  = 3'b100;
    localparam logic [2:0] CTRL_AND = 3'b101;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_shift_add_mul.sv
// Iterative shift-add multiplier: one partial-product step per cycle.
// The step on start_i consumes the operands straight from the ports, so an
// N-step multiply occupies the start cycle plus N-1 further step cycles.
// product_o/last_o describe the step being taken this cycle; the caller
// registers product_o when last_o is set.
// Optional: ALU_MUL_EARLY_EXIT_EN ends the multiply as soon as the remaining
// multiplier bits are all zero.
module shift_add_mul
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] product_o
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] src_a, src_b, src_acc, sum;
    logic [CNT_W-1:0] step_idx;
    logic             last;

    // One shift-add step; operands come from the ports on start, else from the registers.
    always_comb begin
        src_a    = start_i ? a_i : a_q;
        src_b    = start_i ? b_i : b_q;
        src_acc  = start_i ? '0 : acc_q;
        step_idx = start_i ? '0 : cnt_q;
        sum      = src_acc + (src_b[0] ? src_a : '0);
        last     = (step_idx == CNT_W'(WIDTH - 1));
`ifdef ALU_MUL_EARLY_EXIT_EN
        if ((src_b >> 1) == '0) begin
            last = 1'b1;
        end
`endif
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (abort_i) begin
            cnt_d = '0;
        end else if (start_i || step_i) begin
            a_d   = src_a << 1;
            b_d   = src_b >> 1;
            acc_d = sum;
            cnt_d = last ? '0 : step_idx + 1'b1;
        end
        last_o    = last;
        product_o = sum;
    end

    // Multiplier working registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// EX-stage issue controller: accepts ALU requests, executes ADD/SUB/OR/AND in
// one registered cycle and sequences MUL on shift_add_mul while stalling the
// pipeline. flush_i aborts in-flight work and drops same-cycle requests.
// Optional: ALU_MUL_EARLY_EXIT_EN (in shift_add_mul) shortens MUL latency.
//
// state    | meaning
// IDLE     | ready for a request; single-cycle ops complete from here
// MUL_BUSY | multiply iterating; pipeline stalled, requests not sampled
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    input  logic [2:0]       ctrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             stall_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic             accept, is_mul, mul_start, mul_step, mul_last;
    logic [WIDTH-1:0] alu_res, mul_product;

    assign is_mul    = (ctrl_i == CTRL_MUL);
    assign accept    = (state_q == IDLE) && valid_i && !flush_i;
    assign mul_start = accept && is_mul;
    assign mul_step  = (state_q == MUL_BUSY) && !flush_i;

    assign ready_o  = (state_q == IDLE);
    assign stall_o  = mul_start || (state_q == MUL_BUSY);
    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign zero_o   = zero_q;

    shift_add_mul #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .start_i   (mul_start),
        .step_i    (mul_step),
        .abort_i   (flush_i),
        .a_i       (data1_i),
        .b_i       (data2_i),
        .last_o    (mul_last),
        .product_o (mul_product)
    );

    // Single-cycle ALU; unknown codes deliberately yield zero.
    always_comb begin
        case (ctrl_i)
            CTRL_ADD: alu_res = data1_i + data2_i;
            CTRL_SUB: alu_res = data1_i - data2_i;
            CTRL_OR:  alu_res = data1_i | data2_i;
            CTRL_AND: alu_res = data1_i & data2_i;
            default:  alu_res = '0;
        endcase
    end

    // Next state, result capture and valid pulse; flush wins over everything.
    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        if (mul_last) begin
                            result_d = mul_product;
                            valid_d  = 1'b1;
                        end else begin
                            state_d = MUL_BUSY;
                        end
                    end else begin
                        result_d = alu_res;
                        valid_d  = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (mul_last) begin
                    result_d = mul_product;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        zero_d = (result_d == '0);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: single-cycle op table, MUL latency/stall
// sequences, flush and asynchronous reset corner cases.
// Honours ALU_MUL_EARLY_EXIT_EN when the build defines it.
module tb_alu_issue_ctrl;

    localparam logic [2:0] C_ADD = 3'b000;
    localparam logic [2:0] C_SUB = 3'b001;
    localparam logic [2:0] C_MUL = 3'b010;
    localparam logic [2:0] C_OR  = 3'b100;
    localparam logic [2:0] C_AND = 3'b101;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        valid_i;
    logic [2:0]  ctrl_i;
    logic [31:0] data1_i, data2_i;
    logic        flush_i;
    logic        ready_o, stall_o, valid_o, zero_o;
    logic [31:0] result_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t vecs[10];

    alu_issue_ctrl dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .valid_i  (valid_i),
        .ctrl_i   (ctrl_i),
        .data1_i  (data1_i),
        .data2_i  (data2_i),
        .flush_i  (flush_i),
        .ready_o  (ready_o),
        .stall_o  (stall_o),
        .valid_o  (valid_o),
        .result_o (result_o),
        .zero_o   (zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int exp_lat(input logic [31:0] b);
`ifdef ALU_MUL_EARLY_EXIT_EN
        int l = 1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) l = i + 1;
        end
        return l;
`else
        return 32;
`endif
    endfunction

    task automatic do_single(input string name, input logic [2:0] c, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        valid_i = 1'b1; ctrl_i = c; data1_i = a; data2_i = b;
        tick();
        valid_i = 1'b0;
        #1;
        chk({name, "_valid"}, 32'(valid_o), 32'd1);
        chk({name, "_result"}, result_o, exp);
        chk({name, "_zero"}, 32'(zero_o), 32'(exp == 32'd0));
    endtask

    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_p;
        int lat, stall_cnt, rdy_bad, want;
        bit got;
        exp_p = a * b;
        want = exp_lat(b);
        valid_i = 1'b1; ctrl_i = C_MUL; data1_i = a; data2_i = b;
        #1;
        chk({name, "_acc_stall"}, 32'(stall_o), 32'd1);
        chk({name, "_acc_ready"}, 32'(ready_o), 32'd1);
        stall_cnt = 1; lat = 0; rdy_bad = 0; got = 0;
        for (int k = 1; k <= 100 && !got; k++) begin
            tick();
            valid_i = 1'b0;
            #1;
            if (valid_o) begin
                got = 1;
                lat = k;
                chk({name, "_done_stall"}, 32'(stall_o), 32'd0);
            end else if (stall_o) begin
                stall_cnt++;
                if (ready_o) rdy_bad++;
            end
        end
        chk({name, "_latency"}, 32'(lat), 32'(want));
        chk({name, "_stall_cycles"}, 32'(stall_cnt), 32'(want));
        chk({name, "_ready_low"}, 32'(rdy_bad), 32'd0);
        chk({name, "_result"}, result_o, exp_p);
        chk({name, "_zero"}, 32'(zero_o), 32'(exp_p == 32'd0));
        tick();
        chk({name, "_pulse_end"}, 32'(valid_o), 32'd0);
        chk({name, "_hold"}, result_o, exp_p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fb;
        int vcnt;

        vecs[0] = '{C_ADD, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1] = '{C_SUB, 32'd3,          32'd3,          32'd0,          1'b1};
        vecs[2] = '{C_OR,  32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b0};
        vecs[3] = '{C_AND, 32'h0000_00F0,  32'h0000_003C,  32'h0000_0030,  1'b0};
        vecs[4] = '{C_SUB, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
        vecs[5] = '{C_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
        vecs[6] = '{3'b011, 32'd9,         32'd9,          32'd0,          1'b1};
        vecs[7] = '{C_OR,  32'h1234_0000,  32'h0000_5678,  32'h1234_5678,  1'b0};
        vecs[8] = '{C_AND, 32'hAAAA_AAAA,  32'h5555_5555,  32'd0,          1'b1};
        vecs[9] = '{C_ADD, 32'h8000_0001,  32'h8000_0000,  32'd1,          1'b0};

        rst_n_i = 1'b0; valid_i = 1'b0; ctrl_i = '0; data1_i = '0; data2_i = '0; flush_i = 1'b0;
        #12;
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_zero", 32'(zero_o), 32'd1);
        rst_n_i = 1'b1;
        tick();

        // back-to-back single-cycle ops, one result per cycle
        for (int i = 0; i < 10; i++) begin
            valid_i = 1'b1; ctrl_i = vecs[i].ctrl; data1_i = vecs[i].a; data2_i = vecs[i].b;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(ready_o), 32'd1);
            chk($sformatf("vec%0d_stall", i), 32'(stall_o), 32'd0);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(valid_o), 32'd1);
            chk($sformatf("vec%0d_result", i), result_o, vecs[i].res);
            chk($sformatf("vec%0d_zero", i), 32'(zero_o), 32'(vecs[i].zero));
        end
        valid_i = 1'b0;
        tick();
        chk("idle_valid", 32'(valid_o), 32'd0);
        chk("idle_hold", result_o, 32'd1);

        // multiplies
        run_mul("mul_wrap", 32'h0001_0000, 32'h0001_0000);
        run_mul("mul_6x7", 32'd6, 32'd7);
        run_mul("mul_9x3", 32'd9, 32'd3);
        run_mul("mul_x0", 32'h1234_5678, 32'd0);
        run_mul("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mul("mul_mix", 32'h1234_5678, 32'h9ABC_DEF0);

        // flush at busy cycle 10
`ifdef ALU_MUL_EARLY_EXIT_EN
        fb = 32'h8000_0007;
`else
        fb = 32'd7;
`endif
        do_single("pre_flush", C_ADD, 32'd50, 32'd50, 32'd100);
        valid_i = 1'b1; ctrl_i = C_MUL; data1_i = 32'd6; data2_i = fb;
        tick();
        valid_i = 1'b0;
        vcnt = 0;
        for (int k = 1; k < 10; k++) begin
            #1;
            if (valid_o) vcnt++;
            tick();
        end
        flush_i = 1'b1;
        #1;
        if (valid_o) vcnt++;
        chk("flush_busy_stall", 32'(stall_o), 32'd1);
        tick();
        flush_i = 1'b0;
        #1;
        chk("flush_no_valid_busy", 32'(vcnt), 32'd0);
        chk("flush_ready", 32'(ready_o), 32'd1);
        chk("flush_stall", 32'(stall_o), 32'd0);
        chk("flush_valid", 32'(valid_o), 32'd0);
        chk("flush_result", result_o, 32'd100);
        tick();
        chk("flush_no_late_valid", 32'(valid_o), 32'd0);
        do_single("post_flush_add", C_ADD, 32'd1, 32'd1, 32'd2);

        // flush in IDLE drops the request
        valid_i = 1'b1; ctrl_i = C_ADD; data1_i = 32'd3; data2_i = 32'd4; flush_i = 1'b1;
        tick();
        valid_i = 1'b0; flush_i = 1'b0;
        #1;
        chk("idle_flush_valid", 32'(valid_o), 32'd0);
        chk("idle_flush_result", result_o, 32'd2);
        valid_i = 1'b1; ctrl_i = C_MUL; data1_i = 32'd3; data2_i = 32'd4; flush_i = 1'b1;
        #1;
        chk("idle_flush_mul_stall", 32'(stall_o), 32'd0);
        tick();
        valid_i = 1'b0; flush_i = 1'b0;
        #1;
        chk("idle_flush_mul_ready", 32'(ready_o), 32'd1);

        // async reset mid-multiply
        valid_i = 1'b1; ctrl_i = C_MUL; data1_i = 32'd6; data2_i = fb;
        tick();
        valid_i = 1'b0;
        tick();
        tick();
        #1;
        chk("pre_rst_stall", 32'(stall_o), 32'd1);
        rst_n_i = 1'b0;
        #1;
        chk("arst_ready", 32'(ready_o), 32'd1);
        chk("arst_stall", 32'(stall_o), 32'd0);
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_result", result_o, 32'd0);
        chk("arst_zero", 32'(zero_o), 32'd1);
        #2;
        rst_n_i = 1'b1;
        tick();
        do_single("post_rst_add", C_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
        do_single("post_rst_add2", C_ADD, 32'd5, 32'd7, 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
